plab5_mcore_mem_bank_resp: RTL
==============================

PLAB5_MCORE_MEM_BANK_RESP -- requirements
Module: plab5_mcore_MemBankResp

Interface
REQ-001 Parameters SHALL be: p_mem_opaque_nbits, default 8, opaque width; p_mem_addr_nbits, default 32, address width; p_mem_data_nbits, default 32, data width; p_num_words, default 256, bank depth in words (power of two).
REQ-002 Derived widths SHALL be: rqc = 3+opaque+addr+2 (type, opaque, addr, len); rsc = 3+opaque+2 (type, opaque, len); data field width d.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 mode  input  1  1 = domain-partitioned operation, 0 = shared bank.
REQ-006 req_msg_control  input  rqc  request control fields (type, opaque, addr, len).
REQ-007 req_msg_data  input  d  request write data.
REQ-008 req_domain  input  1  security domain of the request.
REQ-009 req_val / req_rdy  input / output  1 each  request valid/ready handshake.
REQ-010 resp_msg_control  output  rsc  response control fields (type, opaque, len).
REQ-011 resp_msg_data  output  d  response read data.
REQ-012 resp_domain  output  1  security domain of the response.
REQ-013 resp_val / resp_rdy  output / input  1 each  response valid/ready handshake.

Function
REQ-014 A transfer SHALL occur on either channel only in a cycle where val and rdy are both 1.
REQ-015 The FSM SHALL have states IDLE, ACCESS, RESP; the state SHALL be IDLE after reset.
REQ-016 In IDLE, req_rdy SHALL be 1; a request transfer latches control, data and domain into a one-entry buffer and moves to ACCESS.
REQ-017 In ACCESS, req_rdy SHALL be 0; the bank read or write is performed and the FSM moves to RESP the following cycle.
REQ-018 In RESP, resp_val SHALL be 1 and req_rdy 0; on resp_rdy=1 the FSM SHALL return to IDLE; otherwise RESP and all response outputs SHALL hold stable.
REQ-019 Minimum latency: request accepted in cycle N SHALL produce resp_val=1 in cycle N+2; throughput SHALL be one request per 3 cycles.
REQ-020 The word index SHALL be addr[log2(p_num_words)+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-021 Type 0 (read) SHALL return the stored word; type 1 (write) SHALL store req data and return data 0; any other type SHALL behave as read.
REQ-022 len SHALL be echoed; every access SHALL be a full-word access regardless of len.
REQ-023 Response type, opaque, len and domain SHALL equal those of the buffered request.
REQ-024 Outside RESP, resp_val SHALL be 0 and resp_msg_control, resp_msg_data and resp_domain SHALL be 0.

Reset
REQ-025 With reset=0 at a clock edge, the FSM SHALL enter IDLE and the request buffer SHALL clear, discarding any in-flight request without a response, including mid-ACCESS or mid-RESP.
REQ-026 After reset: req_rdy=1, resp_val=0, all response fields 0; bank contents SHALL be unchanged.

Configuration
REQ-027 Macro PLAB5_MCORE_MEM_BANK_DOMAIN_CHECK_EN, when defined and mode=1, SHALL restrict domain 0 to the lower half of the bank: domain-0 reads of the upper half SHALL return 0, domain-0 writes to the upper half SHALL be dropped, and the response SHALL still be returned with normal timing.
REQ-028 With the macro undefined, or with mode=0, no access check SHALL apply.

Structure
REQ-029 Field widths, field offsets, type encodings (READ=0, WRITE=1) and FSM state encodings SHALL reside in a shared package or header beside the vc mem message definitions.
REQ-030 Request control field unpacking SHALL use a single sub-module, plab5_mcore_MemReqCtrlUnpack.

Verification
REQ-031 Write type 1, addr 0x10, data 0xDEADBEEF, opaque 0x3, domain 0 accepted in cycle N -> resp_val in cycle N+2; type 1, opaque 0x3, data 0, domain 0.
REQ-032 Read addr 0x10 after the write -> data 0xDEADBEEF; read addr 0x410 (p_num_words=256) -> same word (wrap-around).
REQ-033 Hold resp_rdy=0 for 5 cycles -> response held stable, req_rdy=0 throughout; resp_rdy=1 -> IDLE the next cycle.
REQ-034 Macro defined, mode=1, domain 1 writes 0x55 at addr 0x200, then domain 0 reads 0x200 -> data 0; domain 0 write 0x77 to 0x200 -> a domain 1 read returns 0x55.
REQ-035 Macro undefined, same sequence as REQ-034 -> domain 0 read returns 0x55; after the domain 0 write, a domain 1 read returns 0x77.
REQ-036 reset=0 asserted during ACCESS -> no response is issued, req_rdy=1 in the cycle after reset is released, and a new request completes normally.

Source files
------------

// File: rtl/plab5_mcore_mem_bank_resp_pkg.sv
// Shared field widths, offsets, type codes and FSM states for the memory bank.
// Optional domain check is enabled by PLAB5_MCORE_MEM_BANK_DOMAIN_CHECK_EN.
package plab5_mcore_mem_bank_resp_pkg;

   localparam int TYPE_NBITS = 3;
   localparam int LEN_NBITS  = 2;

   localparam logic [TYPE_NBITS-1:0] MEM_TYPE_READ  = 3'd0;
   localparam logic [TYPE_NBITS-1:0] MEM_TYPE_WRITE = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   function automatic int rqc_nbits(input int opq, input int addr);
      return TYPE_NBITS + opq + addr + LEN_NBITS;
   endfunction

   function automatic int rsc_nbits(input int opq);
      return TYPE_NBITS + opq + LEN_NBITS;
   endfunction

   // Request layout, msb first: type | opaque | addr | len
   function automatic int rq_addr_lsb();
      return LEN_NBITS;
   endfunction

   function automatic int rq_opq_lsb(input int addr);
      return LEN_NBITS + addr;
   endfunction

   function automatic int rq_type_lsb(input int opq, input int addr);
      return LEN_NBITS + addr + opq;
   endfunction

endpackage

// File: rtl/plab5_mcore_mem_bank_resp_unpack.sv
// Splits the packed request control word into type, opaque, addr and len.
// Layout comes from the shared package.
module plab5_mcore_MemReqCtrlUnpack
   import plab5_mcore_mem_bank_resp_pkg::*;
#(
   parameter  int p_mem_opaque_nbits = 8,
   parameter  int p_mem_addr_nbits   = 32,
   localparam int RQC = rqc_nbits(p_mem_opaque_nbits, p_mem_addr_nbits)
) (
   input  logic [RQC-1:0]                ctrl,
   output logic [TYPE_NBITS-1:0]         msg_type,
   output logic [p_mem_opaque_nbits-1:0] msg_opaque,
   output logic [p_mem_addr_nbits-1:0]   msg_addr,
   output logic [LEN_NBITS-1:0]          msg_len
);

   localparam int TYPE_LSB = rq_type_lsb(p_mem_opaque_nbits, p_mem_addr_nbits);
   localparam int OPQ_LSB  = rq_opq_lsb(p_mem_addr_nbits);
   localparam int ADDR_LSB = rq_addr_lsb();

   assign msg_type   = ctrl[TYPE_LSB +: TYPE_NBITS];
   assign msg_opaque = ctrl[OPQ_LSB +: p_mem_opaque_nbits];
   assign msg_addr   = ctrl[ADDR_LSB +: p_mem_addr_nbits];
   assign msg_len    = ctrl[LEN_NBITS-1:0];

endmodule

// File: rtl/plab5_mcore_mem_bank_resp.sv
// Single-bank memory with a one-entry request buffer and IDLE/ACCESS/RESP FSM.
// Define PLAB5_MCORE_MEM_BANK_DOMAIN_CHECK_EN to fence domain 0 from the upper half.
module plab5_mcore_mem_bank_resp
   import plab5_mcore_mem_bank_resp_pkg::*;
#(
   parameter  int p_mem_opaque_nbits = 8,
   parameter  int p_mem_addr_nbits   = 32,
   parameter  int p_mem_data_nbits   = 32,
   parameter  int p_num_words        = 256,
   localparam int RQC = rqc_nbits(p_mem_opaque_nbits, p_mem_addr_nbits),
   localparam int RSC = rsc_nbits(p_mem_opaque_nbits)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mode,
   input  logic [RQC-1:0]              req_msg_control,
   input  logic [p_mem_data_nbits-1:0] req_msg_data,
   input  logic                        req_domain,
   input  logic                        req_val,
   output logic                        req_rdy,
   output logic [RSC-1:0]              resp_msg_control,
   output logic [p_mem_data_nbits-1:0] resp_msg_data,
   output logic                        resp_domain,
   output logic                        resp_val,
   input  logic                        resp_rdy
);

   localparam int IDX_NBITS = $clog2(p_num_words);
   localparam int OPQ_NBITS = p_mem_opaque_nbits;
   localparam int D_NBITS   = p_mem_data_nbits;

   logic [TYPE_NBITS-1:0]       rq_type;
   logic [OPQ_NBITS-1:0]        rq_opq;
   logic [p_mem_addr_nbits-1:0] rq_addr;
   logic [LEN_NBITS-1:0]        rq_len;

   plab5_mcore_MemReqCtrlUnpack #(
      .p_mem_opaque_nbits (p_mem_opaque_nbits),
      .p_mem_addr_nbits   (p_mem_addr_nbits)
   ) u_unpack (
      .ctrl       (req_msg_control),
      .msg_type   (rq_type),
      .msg_opaque (rq_opq),
      .msg_addr   (rq_addr),
      .msg_len    (rq_len)
   );

   // Upper address bits wrap; byte offset is ignored for full-word access.
   logic unused_addr_bits;
   assign unused_addr_bits =
      ^{rq_addr[p_mem_addr_nbits-1:IDX_NBITS+2], rq_addr[1:0]};

   state_e                state_q, state_d;
   logic                  req_rdy_q, req_rdy_d;
   logic                  resp_val_q, resp_val_d;
   logic [RSC-1:0]        resp_ctrl_q, resp_ctrl_d;
   logic [D_NBITS-1:0]    resp_data_q, resp_data_d;
   logic                  resp_dom_q, resp_dom_d;

   logic [TYPE_NBITS-1:0] buf_type_q, buf_type_d;
   logic [OPQ_NBITS-1:0]  buf_opq_q, buf_opq_d;
   logic [IDX_NBITS-1:0]  buf_idx_q, buf_idx_d;
   logic [LEN_NBITS-1:0]  buf_len_q, buf_len_d;
   logic [D_NBITS-1:0]    buf_data_q, buf_data_d;
   logic                  buf_dom_q, buf_dom_d;

   logic [D_NBITS-1:0]    mem_q [p_num_words];

   logic                  blocked;
   logic                  is_write;
   logic                  mem_we;
   logic [D_NBITS-1:0]    rdata;

`ifdef PLAB5_MCORE_MEM_BANK_DOMAIN_CHECK_EN
   assign blocked = mode && !buf_dom_q && buf_idx_q[IDX_NBITS-1];
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign blocked     = 1'b0;
`endif

   assign is_write = (buf_type_q == MEM_TYPE_WRITE);
   assign mem_we   = reset && (state_q == ST_ACCESS) && is_write && !blocked;
   assign rdata    = blocked ? '0 : mem_q[buf_idx_q];

   always_comb begin
      state_d     = state_q;
      req_rdy_d   = req_rdy_q;
      resp_val_d  = resp_val_q;
      resp_ctrl_d = resp_ctrl_q;
      resp_data_d = resp_data_q;
      resp_dom_d  = resp_dom_q;
      buf_type_d  = buf_type_q;
      buf_opq_d   = buf_opq_q;
      buf_idx_d   = buf_idx_q;
      buf_len_d   = buf_len_q;
      buf_data_d  = buf_data_q;
      buf_dom_d   = buf_dom_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_val && req_rdy_q) begin
               buf_type_d = rq_type;
               buf_opq_d  = rq_opq;
               buf_idx_d  = rq_addr[IDX_NBITS+1:2];
               buf_len_d  = rq_len;
               buf_data_d = req_msg_data;
               buf_dom_d  = req_domain;
               req_rdy_d  = 1'b0;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_d     = ST_RESP;
            resp_val_d  = 1'b1;
            resp_ctrl_d = {buf_type_q, buf_opq_q, buf_len_q};
            resp_data_d = is_write ? '0 : rdata;
            resp_dom_d  = buf_dom_q;
         end
         ST_RESP: begin
            if (resp_rdy) begin
               state_d     = ST_IDLE;
               req_rdy_d   = 1'b1;
               resp_val_d  = 1'b0;
               resp_ctrl_d = '0;
               resp_data_d = '0;
               resp_dom_d  = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            req_rdy_d   = 1'b1;
            resp_val_d  = 1'b0;
            resp_ctrl_d = '0;
            resp_data_d = '0;
            resp_dom_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         req_rdy_q   <= 1'b1;
         resp_val_q  <= 1'b0;
         resp_ctrl_q <= '0;
         resp_data_q <= '0;
         resp_dom_q  <= 1'b0;
         buf_type_q  <= '0;
         buf_opq_q   <= '0;
         buf_idx_q   <= '0;
         buf_len_q   <= '0;
         buf_data_q  <= '0;
         buf_dom_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_rdy_q   <= req_rdy_d;
         resp_val_q  <= resp_val_d;
         resp_ctrl_q <= resp_ctrl_d;
         resp_data_q <= resp_data_d;
         resp_dom_q  <= resp_dom_d;
         buf_type_q  <= buf_type_d;
         buf_opq_q   <= buf_opq_d;
         buf_idx_q   <= buf_idx_d;
         buf_len_q   <= buf_len_d;
         buf_data_q  <= buf_data_d;
         buf_dom_q   <= buf_dom_d;
      end
   end

   // Bank storage survives reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[buf_idx_q] <= buf_data_q;
      end
   end

   assign req_rdy          = req_rdy_q;
   assign resp_val         = resp_val_q;
   assign resp_msg_control = resp_ctrl_q;
   assign resp_msg_data    = resp_data_q;
   assign resp_domain      = resp_dom_q;

endmodule
